// File: rtl/regsel_uop_sequencer.sv
// -----------------------------------------------------------------------------
// regsel_uop_sequencer
//
// Decode-stage register-file select sequencer. Accepts one instruction per
// instr_valid/instr_ready handshake and issues a registered micro-op holding
// the three register-file MUX selects and a stack-pointer operation. Interrupt
// entry (push PC, push FLAGS) and RTI (pop FLAGS, pop PC) are sequenced over
// two cycles. A downstream stall freezes the whole block.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   instr        {opcode, ra/brx, rb}
//   instr_valid  instruction presented
//   instr_ready  combinational accept: RUN, not stalled, no interrupt pending
//   int_req      level interrupt request, held until int_ack
//   int_ack      registered one-cycle acknowledge (held while stalled)
//   stall_in     downstream stall, freezes state and all registered outputs
//   uop_valid    uop outputs below are meaningful
//   sd1          write-address select: 0 = IR[ra], 1 = SP_IDX
//   sd2          read-A select: 0 = immediate, 1 = R[ra]
//   sd3          read-B select: 0 = R[rb], 1 = PC+1, 2 = PC, 3 = FLAGS
//   sp_op        00 none, 01 push (SP--), 10 pop (++SP)
//   wa_sp        constant SP register index
//   busy         sequencer is mid multi-cycle operation
// -----------------------------------------------------------------------------
module regsel_uop_sequencer #(
    parameter int OPW       = 4,
    parameter int RAW       = 2,
    parameter int SP_IDX    = 3,
    parameter int OP_STACK  = 7,
    parameter int OP_BRANCH = 11,
    parameter int OP_LDI    = 12,
    localparam int IW       = OPW + 2 * RAW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [IW-1:0]  instr,
    input  logic           instr_valid,
    output logic           instr_ready,
    input  logic           int_req,
    output logic           int_ack,
    input  logic           stall_in,
    output logic           uop_valid,
    output logic           sd1,
    output logic           sd2,
    output logic [1:0]     sd3,
    output logic [1:0]     sp_op,
    output logic [RAW-1:0] wa_sp,
    output logic           busy
);

    // INT_PC is kept as an encoding only; the PC push is issued straight
    // from RUN, so the FSM never enters it.
    typedef enum logic [2:0] {
        RUN     = 3'd0,
        INT_PC  = 3'd1,
        INT_FLG = 3'd2,
        RTI_FLG = 3'd3,
        RTI_PC  = 3'd4
    } state_e;

    localparam logic [OPW-1:0] OPC_STACK  = OPW'(OP_STACK);
    localparam logic [OPW-1:0] OPC_BRANCH = OPW'(OP_BRANCH);
    localparam logic [OPW-1:0] OPC_LDI    = OPW'(OP_LDI);

    localparam logic [1:0] SD3_RB    = 2'd0;
    localparam logic [1:0] SD3_PC1   = 2'd1;
    localparam logic [1:0] SD3_PC    = 2'd2;
    localparam logic [1:0] SD3_FLAGS = 2'd3;

    localparam logic [1:0] SP_NONE = 2'b00;
    localparam logic [1:0] SP_PUSH = 2'b01;
    localparam logic [1:0] SP_POP  = 2'b10;

    state_e     state_q, state_d;
    logic       uop_valid_q, uop_valid_d;
    logic       sd1_q, sd1_d;
    logic       sd2_q, sd2_d;
    logic [1:0] sd3_q, sd3_d;
    logic [1:0] sp_op_q, sp_op_d;
    logic       int_ack_q, int_ack_d;

    logic [OPW-1:0] opcode;
    logic [RAW-1:0] ra;
    logic           unused_rb;

    assign opcode = instr[IW-1 -: OPW];
    assign ra     = instr[2*RAW-1:RAW];
    // rb only steers the datapath MUX directly, not this sequencer.
    assign unused_rb = ^instr[RAW-1:0];

    assign instr_ready = (state_q == RUN) && !stall_in && !int_req;
    assign busy        = (state_q != RUN);
    assign wa_sp       = RAW'(SP_IDX);

    // NOTE: every signal written here gets a default first, so no path
    // through the case statements can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        uop_valid_d = 1'b0;
        sd1_d       = 1'b0;
        sd2_d       = 1'b1;
        sd3_d       = SD3_RB;
        sp_op_d     = SP_NONE;
        int_ack_d   = 1'b0;

        if (stall_in) begin
            // Freeze: hold state and every registered output, including a
            // pending int_ack, so nothing is lost or replayed across a stall.
            state_d     = state_q;
            uop_valid_d = uop_valid_q;
            sd1_d       = sd1_q;
            sd2_d       = sd2_q;
            sd3_d       = sd3_q;
            sp_op_d     = sp_op_q;
            int_ack_d   = int_ack_q;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (int_req) begin
                        // Interrupt wins over instr_valid: push PC now.
                        uop_valid_d = 1'b1;
                        sd1_d       = 1'b1;
                        sd3_d       = SD3_PC;
                        sp_op_d     = SP_PUSH;
                        state_d     = INT_FLG;
                    end else if (instr_valid && instr_ready) begin
                        uop_valid_d = 1'b1;
                        if (opcode == OPC_STACK) begin
                            if (ra == RAW'(0)) begin
                                sd1_d   = 1'b1;
                                sp_op_d = SP_PUSH;
                            end else if (ra == RAW'(1)) begin
                                sd1_d   = 1'b1;
                                sp_op_d = SP_POP;
                            end
                        end else if (opcode == OPC_LDI) begin
                            sd2_d = 1'b0;
                        end else if (opcode == OPC_BRANCH) begin
                            if (ra == RAW'(1)) begin
                                // CALL: push return address
                                sd1_d   = 1'b1;
                                sd3_d   = SD3_PC1;
                                sp_op_d = SP_PUSH;
                            end else if (ra == RAW'(2)) begin
                                // RET: pop PC
                                sd1_d   = 1'b1;
                                sp_op_d = SP_POP;
                            end else if (ra == RAW'(3)) begin
                                // RTI: this uop pops FLAGS, PC pop follows
                                sd1_d   = 1'b1;
                                sp_op_d = SP_POP;
                                state_d = RTI_PC;
                            end
                        end
                    end
                end
                INT_FLG: begin
                    uop_valid_d = 1'b1;
                    sd1_d       = 1'b1;
                    sd3_d       = SD3_FLAGS;
                    sp_op_d     = SP_PUSH;
                    int_ack_d   = 1'b1;
                    state_d     = RUN;
                end
                RTI_PC: begin
                    uop_valid_d = 1'b1;
                    sd1_d       = 1'b1;
                    sp_op_d     = SP_POP;
                    state_d     = RUN;
                end
                default: begin
                    // Unreachable encodings recover to RUN with an idle uop.
                    state_d = RUN;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            uop_valid_q <= 1'b0;
            sd1_q       <= 1'b0;
            sd2_q       <= 1'b1;
            sd3_q       <= SD3_RB;
            sp_op_q     <= SP_NONE;
            int_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            uop_valid_q <= uop_valid_d;
            sd1_q       <= sd1_d;
            sd2_q       <= sd2_d;
            sd3_q       <= sd3_d;
            sp_op_q     <= sp_op_d;
            int_ack_q   <= int_ack_d;
        end
    end

    assign uop_valid = uop_valid_q;
    assign sd1       = sd1_q;
    assign sd2       = sd2_q;
    assign sd3       = sd3_q;
    assign sp_op     = sp_op_q;
    assign int_ack   = int_ack_q;

endmodule

// File: tb/tb_regsel_uop_sequencer.sv
// -----------------------------------------------------------------------------
// tb_regsel_uop_sequencer
//
// Directed testbench for regsel_uop_sequencer. Stimulus pushes the expected
// uop ({int_ack, sd1, sd2, sd3, sp_op}) into a queue; a negedge monitor pops
// and compares each consumed uop (uop_valid while not stalled and out of
// reset) and checks the idle pattern on cycles with no uop.
// -----------------------------------------------------------------------------
module tb_regsel_uop_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic       int_req;
    logic       int_ack;
    logic       stall_in;
    logic       uop_valid;
    logic       sd1;
    logic       sd2;
    logic [1:0] sd3;
    logic [1:0] sp_op;
    logic [1:0] wa_sp;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] exp_q[$];

    regsel_uop_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .int_req     (int_req),
        .int_ack     (int_ack),
        .stall_in    (stall_in),
        .uop_valid   (uop_valid),
        .sd1         (sd1),
        .sd2         (sd2),
        .sd3         (sd3),
        .sp_op       (sp_op),
        .wa_sp       (wa_sp),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic ack, input logic s1, input logic s2,
                            input logic [1:0] s3, input logic [1:0] sp);
        exp_q.push_back({ack, s1, s2, s3, sp});
    endtask

    // Called at posedge+1; presents one instruction for one clock.
    task automatic send(input logic [7:0] ins);
        instr       = ins;
        instr_valid = 1'b1;
        #1;
        check("instr_ready_before_accept", instr_ready, 1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    // Monitor: a uop is consumed on a cycle where it is valid and not stalled.
    always @(negedge clk) begin
        if (rst_n && !stall_in) begin
            if (uop_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_uop: got 0x%0h with empty scoreboard at %0t",
                             {int_ack, sd1, sd2, sd3, sp_op}, $time);
                end else begin
                    check("uop", {25'd0, int_ack, sd1, sd2, sd3, sp_op}, {25'd0, exp_q.pop_front()});
                end
            end else begin
                check("idle_uop", {25'd0, int_ack, sd1, sd2, sd3, sp_op}, 32'b0_0_1_00_00);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        instr       = 8'h00;
        instr_valid = 1'b0;
        int_req     = 1'b0;
        stall_in    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        check("rst_uop_valid", uop_valid, 0);
        check("rst_sd1", sd1, 0);
        check("rst_sd2", sd2, 1);
        check("rst_sd3", sd3, 0);
        check("rst_sp_op", sp_op, 0);
        check("rst_int_ack", int_ack, 0);
        check("rst_busy", busy, 0);
        check("rst_instr_ready", instr_ready, 1);
        check("wa_sp", wa_sp, 3);
        @(posedge clk);
        #1;

        // PUSH, POP, LDI, default
        push_exp(0, 1, 1, 2'd0, 2'b01); send(8'h70);
        push_exp(0, 1, 1, 2'd0, 2'b10); send(8'h74);
        push_exp(0, 0, 0, 2'd0, 2'b00); send(8'hC5);
        push_exp(0, 0, 1, 2'd0, 2'b00); send(8'h23);

        // CALL then RTI (two pops, ready low one cycle)
        push_exp(0, 1, 1, 2'd1, 2'b01); send(8'hB4);
        push_exp(0, 1, 1, 2'd0, 2'b10);
        push_exp(0, 1, 1, 2'd0, 2'b10);
        send(8'hBC);
        check("rti_ready_low", instr_ready, 0);
        check("rti_busy", busy, 1);
        @(posedge clk);
        #1;
        check("rti_ready_back", instr_ready, 1);
        check("rti_busy_clear", busy, 0);
        @(posedge clk);
        #1;

        // Interrupt beats a valid instruction
        int_req     = 1'b1;
        instr       = 8'h70;
        instr_valid = 1'b1;
        push_exp(0, 1, 1, 2'd2, 2'b01);
        push_exp(1, 1, 1, 2'd3, 2'b01);
        #1;
        check("int_ready_low", instr_ready, 0);
        @(posedge clk);
        #1;
        check("int_flg_busy", busy, 1);
        check("int_flg_ready", instr_ready, 0);
        check("int_ack_not_yet", int_ack, 0);
        @(posedge clk);
        #1;
        check("int_ack_pulse", int_ack, 1);
        int_req     = 1'b0;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("int_ack_cleared", int_ack, 0);

        // Interrupt with a 3-cycle stall while in INT_FLG
        int_req = 1'b1;
        push_exp(0, 1, 1, 2'd2, 2'b01);
        push_exp(1, 1, 1, 2'd3, 2'b01);
        @(posedge clk);
        #1;
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("stall_sd3_frozen", sd3, 2);
            check("stall_ack_held_low", int_ack, 0);
            check("stall_busy", busy, 1);
            check("stall_ready_low", instr_ready, 0);
        end
        stall_in = 1'b0;
        @(posedge clk);
        #1;
        check("stall_int_ack_once", int_ack, 1);
        int_req = 1'b0;
        @(posedge clk);
        #1;
        check("stall_int_ack_gone", int_ack, 0);

        // Reset while in RTI_PC: the pending flags-pop uop is discarded
        send(8'hBC);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_uop_valid", uop_valid, 0);
        check("mid_rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("post_rst_ready", instr_ready, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_sd2", sd2, 1);
        @(posedge clk);
        #1;
        check("post_rst_no_partial_uop", uop_valid, 0);

        // Recovery
        push_exp(0, 1, 1, 2'd0, 2'b01); send(8'h70);

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
